// File: rtl/ascon_block_packer.sv
// Packs a narrow valid/ready word stream into left-aligned 64/128-bit ASCON rate blocks,
// applying 10* padding (including the padding-only block) on the final block of a message.
module ascon_block_packer #(
  parameter int BUS_W  = 32,
  parameter bit PAD_EN = 1'b1
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic                       abort,
  input  logic                       rate_sel,
  input  logic [BUS_W-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic [$clog2(BUS_W/8):0]   s_bytes,
  output logic [127:0]               blk_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic                       blk_last,
  output logic [4:0]                 blk_bytes,
  output logic                       err
);

  localparam int BB     = BUS_W / 8;
  localparam int SBW    = $clog2(BB) + 1;
  localparam int WPB_HI = 128 / BUS_W;
  localparam int WPB_LO = 64 / BUS_W;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [3:0]     idx_r;
  logic           rate_r;
  logic           in_msg_r;
  logic           pad_pending_r;
  logic [127:0]   acc_r;
  logic [127:0]   blk_data_r;
  logic           blk_last_r;
  logic [4:0]     blk_bytes_r;
  logic           err_r;

  logic           accept_s;
  logic           rate_eff_s;
  logic [3:0]     last_idx_s;
  logic           close_s;
  logic           bad_bytes_s;
  logic [SBW-1:0] nb_s;
  logic [5:0]     n_s;
  logic [5:0]     rate_bytes_s;
  logic [BUS_W-1:0] byte_mask_s;
  logic [7:0]     word_shift_s;
  logic [7:0]     pad_shift_s;
  logic [127:0]   block_s;

  assign accept_s = s_valid && (state_r == FILL);

  // Slot placement, byte masking, byte count and 10* padding for the incoming word
  always_comb begin
    // the rate is only taken from rate_sel on the first word of a message
    rate_eff_s   = (idx_r == 4'd0 && !in_msg_r) ? rate_sel : rate_r;
    last_idx_s   = rate_eff_s ? 4'(WPB_HI - 1) : 4'(WPB_LO - 1);
    rate_bytes_s = rate_eff_s ? 6'd16 : 6'd8;
    close_s      = s_last || (idx_r == last_idx_s);
    bad_bytes_s  = (s_bytes > SBW'(BB));
    nb_s         = (!s_last || bad_bytes_s) ? SBW'(BB) : s_bytes;
    n_s          = 6'(idx_r) * 6'(BB) + 6'(nb_s);
    byte_mask_s  = {BUS_W{1'b0}};
    for (int b = 0; b < BB; b++) begin
      byte_mask_s[BUS_W-1-8*b -: 8] = (b < int'(nb_s)) ? 8'hFF : 8'h00;
    end
    word_shift_s = 8'd128 - 8'(BUS_W) * (8'(idx_r) + 8'd1);
    pad_shift_s  = 8'd120 - {n_s[4:0], 3'b000};
    block_s      = acc_r | (128'(s_data & byte_mask_s) << word_shift_s);
    if (s_last && PAD_EN && (n_s < rate_bytes_s)) begin
      block_s = block_s | (128'h80 << pad_shift_s);
    end else begin
      block_s = block_s;
    end
  end

  // Next-state decode; abort overrides every other event
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s && close_s) state_s = HOLD;
          else                     state_s = FILL;
        end
        HOLD: begin
          if (blk_ready) state_s = pad_pending_r ? PAD : FILL;
          else           state_s = HOLD;
        end
        PAD: begin
          if (blk_ready) state_s = FILL;
          else           state_s = PAD;
        end
        default: state_s = FILL;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_r <= FILL;
    else          state_r <= state_s;
  end

  // Accumulator, emitted block registers and sticky error flag
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      idx_r         <= 4'd0;
      rate_r        <= 1'b0;
      in_msg_r      <= 1'b0;
      pad_pending_r <= 1'b0;
      acc_r         <= 128'd0;
      blk_data_r    <= 128'd0;
      blk_last_r    <= 1'b0;
      blk_bytes_r   <= 5'd0;
      err_r         <= 1'b0;
    end else if (abort) begin
      idx_r         <= 4'd0;
      in_msg_r      <= 1'b0;
      pad_pending_r <= 1'b0;
      acc_r         <= 128'd0;
      blk_data_r    <= 128'd0;
      blk_last_r    <= 1'b0;
      blk_bytes_r   <= 5'd0;
    end else begin
      if (accept_s) begin
        if (s_last && bad_bytes_s) err_r <= 1'b1;
        rate_r   <= rate_eff_s;
        in_msg_r <= !s_last;
        if (close_s) begin
          acc_r       <= 128'd0;
          idx_r       <= 4'd0;
          blk_data_r  <= block_s;
          blk_bytes_r <= n_s[4:0];
          // a message ending exactly on the rate boundary needs a padding-only block
          if (s_last && !(PAD_EN && (n_s == rate_bytes_s))) begin
            blk_last_r    <= 1'b1;
            pad_pending_r <= 1'b0;
          end else begin
            blk_last_r    <= 1'b0;
            pad_pending_r <= s_last;
          end
        end else begin
          acc_r <= block_s;
          idx_r <= idx_r + 4'd1;
        end
      end
      if (state_r == HOLD && blk_ready && pad_pending_r) begin
        blk_data_r    <= {8'h80, 120'd0};
        blk_last_r    <= 1'b1;
        blk_bytes_r   <= 5'd0;
        pad_pending_r <= 1'b0;
      end
    end
  end

  assign s_ready   = (state_r == FILL);
  assign blk_valid = (state_r != FILL);
  assign blk_data  = blk_data_r;
  assign blk_last  = blk_last_r;
  assign blk_bytes = blk_bytes_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Randomised and directed bench for ascon_block_packer; blocks are predicted by a byte-level
// message model and compared at every blk_valid/blk_ready handshake.
module tb_ascon_block_packer;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
    logic [4:0]   bytes;
  } blk_t;

  logic         clock = 1'b0;
  logic         n_reset, abort;
  logic         rate_sel, s_valid, s_last, blk_ready;
  logic [31:0]  s_data;
  logic [2:0]   s_bytes;
  logic         s_ready, blk_valid, blk_last, err;
  logic [127:0] blk_data;
  logic [4:0]   blk_bytes;

  logic         rate_sel0, s_valid0, s_last0, blk_ready0;
  logic [31:0]  s_data0;
  logic [2:0]   s_bytes0;
  logic         s_ready0, blk_valid0, blk_last0, err0;
  logic [127:0] blk_data0;
  logic [4:0]   blk_bytes0;

  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  bit   exp_err = 1'b0;
  blk_t exp_q[$];
  blk_t exp0_q[$];
  logic [31:0] wq[$];

  always #5 clock = ~clock;

  ascon_block_packer #(.BUS_W(32), .PAD_EN(1'b1)) dut (
    .clock(clock), .n_reset(n_reset), .abort(abort), .rate_sel(rate_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_bytes(s_bytes), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_last(blk_last), .blk_bytes(blk_bytes), .err(err)
  );

  ascon_block_packer #(.BUS_W(32), .PAD_EN(1'b0)) dut0 (
    .clock(clock), .n_reset(n_reset), .abort(abort), .rate_sel(rate_sel0),
    .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0), .s_last(s_last0),
    .s_bytes(s_bytes0), .blk_data(blk_data0), .blk_valid(blk_valid0),
    .blk_ready(blk_ready0), .blk_last(blk_last0), .blk_bytes(blk_bytes0), .err(err0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Message model: split the byte stream into word-aligned blocks and apply 10* padding.
  function automatic void build_exp(input logic [31:0] w[$], input int nb_last,
                                    input bit rate, input bit pad_en);
    int rb, wpb, nb, nwords;
    bit lastw;
    byte unsigned blk[$];
    blk_t e;
    rb = rate ? 16 : 8;
    wpb = rb / 4;
    nwords = 0;
    for (int i = 0; i < w.size(); i++) begin
      lastw = (i == w.size() - 1);
      nb = lastw ? ((nb_last > 4) ? 4 : nb_last) : 4;
      for (int b = 0; b < nb; b++) blk.push_back(w[i][31-8*b -: 8]);
      nwords++;
      if (nwords == wpb || lastw) begin
        e.d = '0;
        for (int b = 0; b < blk.size(); b++) e.d[127-8*b -: 8] = blk[b];
        e.bytes = 5'(blk.size());
        if (lastw && pad_en && blk.size() == rb) begin
          e.last = 1'b0;
          exp_q.push_back(e);
          e.d = {8'h80, 120'd0};
          e.last = 1'b1;
          e.bytes = 5'd0;
          exp_q.push_back(e);
        end else begin
          if (lastw && pad_en) e.d[127-8*blk.size() -: 8] = 8'h80;
          e.last = lastw;
          if (pad_en) exp_q.push_back(e);
          else        exp0_q.push_back(e);
        end
        blk.delete();
        nwords = 0;
      end
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb, input bit rs);
    int t = 0;
    s_data = d; s_last = last; s_bytes = nb; rate_sel = rs; s_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (s_ready || t > 300) break;
      t++;
    end
    if (!s_ready) check("s_ready_wait", s_ready, 1'b1);
    @(posedge clock); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = $urandom;
  endtask

  task automatic send_word0(input logic [31:0] d, input bit last, input logic [2:0] nb, input bit rs);
    int t = 0;
    s_data0 = d; s_last0 = last; s_bytes0 = nb; rate_sel0 = rs; s_valid0 = 1'b1;
    forever begin
      @(negedge clock);
      if (s_ready0 || t > 300) break;
      t++;
    end
    if (!s_ready0) check("s_ready0_wait", s_ready0, 1'b1);
    @(posedge clock); #1;
    s_valid0 = 1'b0; s_last0 = 1'b0;
  endtask

  task automatic send_q(input logic [31:0] w[$], input int nb, input bit rate, input bit gaps);
    build_exp(w, nb, rate, 1'b1);
    if (nb > 4) exp_err = 1'b1;
    for (int i = 0; i < w.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      send_word(w[i], i == w.size() - 1, 3'(nb), (i == 0) ? rate : 1'($urandom));
    end
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && t < 1000) begin
      @(posedge clock); #1;
      t++;
    end
    check("drain", 128'(exp_q.size() + exp0_q.size()), 128'd0);
    @(posedge clock); #1;
  endtask

  // blk_ready drivers
  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0:       blk_ready = 1'b1;
      1:       blk_ready = ($urandom_range(0, 3) != 0);
      default: blk_ready = 1'b0;
    endcase
    blk_ready0 = 1'b1;
  end

  // Handshake monitors
  initial forever begin
    blk_t e;
    @(negedge clock);
    if (n_reset && blk_valid && blk_ready) begin
      check("exp_avail", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("blk_data", blk_data, e.d);
        check("blk_last", blk_last, e.last);
        check("blk_bytes", blk_bytes, e.bytes);
      end
    end
    if (n_reset && blk_valid0 && blk_ready0) begin
      check("exp0_avail", exp0_q.size() != 0, 1'b1);
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        check("blk_data0", blk_data0, e.d);
        check("blk_last0", blk_last0, e.last);
        check("blk_bytes0", blk_bytes0, e.bytes);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; abort = 1'b0; rate_sel = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = 32'd0; s_bytes = 3'd0; blk_ready = 1'b1;
    rate_sel0 = 1'b0; s_valid0 = 1'b0; s_last0 = 1'b0; s_data0 = 32'd0; s_bytes0 = 3'd0;
    blk_ready0 = 1'b1;
    #12;
    check("rst_blk_data", blk_data, 128'd0);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_last", blk_last, 1'b0);
    check("rst_blk_bytes", blk_bytes, 5'd0);
    check("rst_err", err, 1'b0);
    @(negedge clock); n_reset = 1'b1;
    @(posedge clock); #1;
    check("rst_s_ready", s_ready, 1'b1);

    // rate 128, full block then padding-only block with no bubble
    wq = {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    send_q(wq, 4, 1'b1, 1'b0);
    check("latency_valid", blk_valid, 1'b1);
    @(posedge clock); #1;
    check("pad_no_bubble", blk_valid, 1'b1);
    check("pad_last", blk_last, 1'b1);
    drain();

    // rate 64, one full block then a 1-byte padded block
    wq = {32'h01020304, 32'h05060708, 32'hAB000000};
    send_q(wq, 1, 1'b0, 1'b0);
    drain();

    // empty message
    wq = {32'hDEADBEEF};
    send_q(wq, 0, 1'b1, 1'b0);
    drain();

    // hold with blk_ready low; source pulses must not be consumed
    rdy_mode = 2;
    repeat (2) begin @(posedge clock); #1; end
    wq = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_q(wq, 4, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = $urandom;
      @(negedge clock);
      check("hold_data", blk_data, exp_q[0].d);
      check("hold_s_ready", s_ready, 1'b0);
      check("hold_valid", blk_valid, 1'b1);
      @(posedge clock); #1;
      s_valid = 1'b0;
    end
    rdy_mode = 0;
    drain();

    // abort after two words, then a fresh message
    send_word(32'hFFFFFFFF, 1'b0, 3'd4, 1'b1);
    send_word(32'hEEEEEEEE, 1'b0, 3'd4, 1'b1);
    pulse_abort();
    check("abort_valid", blk_valid, 1'b0);
    check("abort_s_ready", s_ready, 1'b1);
    wq = {32'h0A0B0C0D, 32'h10203040, 32'h55667788, 32'h99AABBCC};
    send_q(wq, 3, 1'b1, 1'b0);
    drain();

    // abort while a block is held
    rdy_mode = 2;
    repeat (2) begin @(posedge clock); #1; end
    wq = {32'h12345678};
    send_q(wq, 2, 1'b0, 1'b0);
    exp_q.delete();
    pulse_abort();
    check("abort_hold_valid", blk_valid, 1'b0);
    check("abort_hold_last", blk_last, 1'b0);
    check("abort_hold_bytes", blk_bytes, 5'd0);
    rdy_mode = 0;
    repeat (2) begin @(posedge clock); #1; end

    // over-range s_bytes: sticky err, clamped to a full word
    wq = {32'h01020304, 32'hA1B2C3D4};
    send_q(wq, 5, 1'b0, 1'b0);
    drain();
    check("err_set", err, exp_err);
    wq = {32'h5A5A5A5A};
    send_q(wq, 2, 1'b1, 1'b0);
    drain();
    check("err_sticky", err, exp_err);

    // n_reset pulse mid-block
    send_word(32'h77777777, 1'b0, 3'd4, 1'b1);
    send_word(32'h88888888, 1'b0, 3'd4, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    exp_err = 1'b0;
    check("nrst_blk_data", blk_data, 128'd0);
    check("nrst_blk_valid", blk_valid, 1'b0);
    check("nrst_blk_last", blk_last, 1'b0);
    check("nrst_blk_bytes", blk_bytes, 5'd0);
    check("nrst_err", err, exp_err);
    check("nrst_s_ready", s_ready, 1'b1);
    @(negedge clock); n_reset = 1'b1;
    @(posedge clock); #1;
    wq = {32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3, 32'hF0F1F2F3};
    send_q(wq, 4, 1'b1, 1'b0);
    drain();

    // zero-fill variant: empty message, then an exact-boundary message with no pad block
    wq = {32'hCAFEF00D};
    build_exp(wq, 0, 1'b1, 1'b0);
    send_word0(32'hCAFEF00D, 1'b1, 3'd0, 1'b1);
    drain();
    check("nopad_s_ready", s_ready0, 1'b1);
    wq = {32'hAABBCCDD, 32'h11223344};
    build_exp(wq, 4, 1'b0, 1'b0);
    send_word0(32'hAABBCCDD, 1'b0, 3'd4, 1'b0);
    send_word0(32'h11223344, 1'b1, 3'd4, 1'b1);
    drain();
    check("nopad_no_pad_blk", blk_valid0, 1'b0);

    // randomised messages with random gaps and backpressure
    rdy_mode = 1;
    for (int m = 0; m < 40; m++) begin
      int nw, nb;
      nw = $urandom_range(1, 9);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      wq.delete();
      repeat (nw) wq.push_back($urandom);
      send_q(wq, nb, 1'($urandom), 1'b1);
    end
    drain();
    check("err_final", err, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
